// File: rtl/data_mem_pkg.sv
// Package: data_mem_pkg
// Shared constants for the float-add data memory.
//   DEF_DW / DEF_AW : default data and address widths (8 / 8 -> 256 x 8).
//   OPA_*, OPB_*, RES_* : fixed byte addresses of the half-precision operands
//                         and result used by the datapath controller.
//   SIGN_BIT, EXP_MSB, EXP_LSB, MANT_HI_MSB : field positions inside the
//                         high byte of a half-precision word.
// The memory itself gives these addresses no special meaning.
package data_mem_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;

  // Half-precision word map: low byte at the even address, high byte next.
  localparam logic [7:0] OPA_LO = 8'd8;
  localparam logic [7:0] OPA_HI = 8'd9;
  localparam logic [7:0] OPB_LO = 8'd10;
  localparam logic [7:0] OPB_HI = 8'd11;
  localparam logic [7:0] RES_LO = 8'd12;
  localparam logic [7:0] RES_HI = 8'd13;

  // High-byte layout: sign [7], exponent [6:2], mantissa[9:8] at [1:0].
  localparam int SIGN_BIT    = 7;
  localparam int EXP_MSB     = 6;
  localparam int EXP_LSB     = 2;
  localparam int MANT_HI_MSB = 1;

  // Exponent field of a half-precision high byte.
  function automatic logic [EXP_MSB-EXP_LSB:0] hp_exp(input logic [7:0] hi_byte);
    return hi_byte[EXP_MSB:EXP_LSB];
  endfunction

  // Sign bit of a half-precision high byte.
  function automatic logic hp_sign(input logic [7:0] hi_byte);
    return hi_byte[SIGN_BIT];
  endfunction

endpackage

// File: rtl/data_mem_256x8.sv
// Module: data_mem_256x8
// Byte-addressed 2**AW x DW data memory (256 x 8 by default) with one
// synchronous write port and one read port sharing a single address.
//
// Ports:
//   clk     in  1   : clock; writes happen on its rising edge
//   reset   in  1   : asynchronous, active-low; clears the array and the
//                     optional read register
//   wr_en   in  1   : write enable
//   addr    in  AW  : shared read/write address (full range, no aliasing)
//   dat_in  in  DW  : write data
//   dat_out out DW  : read data at addr
//
// Build option DATA_MEM_RDREG_EN:
//   undefined : dat_out is a combinational read of mem_core[addr].
//   defined   : dat_out is a register loaded every edge with a write-first
//               read of addr (dat_in when wr_en is high), cleared on reset.
//
// mem_core is a plain variable driven from a plain always block so that a
// bench or controller may legally poke it through the hierarchy.
module data_mem_256x8
  import data_mem_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_core [DEPTH];

  // Storage: reset clears every entry at once and blocks writes while low.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_core[i] <= '0;
      end
    end else if (wr_en) begin
      mem_core[addr] <= dat_in;
    end
  end

`ifdef DATA_MEM_RDREG_EN
  logic [DW-1:0] rd_d;
  logic [DW-1:0] rd_q;

  // Write-first: a same-address write shows its new data after one edge.
  always_comb begin
    rd_d = mem_core[addr];
    if (wr_en) begin
      rd_d = dat_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign dat_out = rd_q;
`else
  // The cleared array already yields 0 while reset is held low.
  assign dat_out = mem_core[addr];
`endif

endmodule

// File: tb/tb_data_mem_256x8.sv
module tb_data_mem_256x8;
  import data_mem_pkg::*;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] dat_in;
  logic [7:0] dat_out;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  data_mem_256x8 #(.DW(8), .AW(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .addr    (addr),
    .dat_in  (dat_in),
    .dat_out (dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a plain byte array plus, for the registered build, the value
  // the output register must hold.
  logic [7:0] model [256];
  logic [7:0] exp_q;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
      exp_q = 8'h00;
    end else begin
      exp_q = wr_en ? dat_in : model[addr];
      if (wr_en) model[addr] = dat_in;
    end
  end

  function automatic logic [7:0] expected_out();
`ifdef DATA_MEM_RDREG_EN
    return exp_q;
`else
    return reset ? model[addr] : 8'h00;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) check("model_cmp", dat_out, expected_out());
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic we);
    @(posedge clk);
    #2;
    addr   = a;
    dat_in = d;
    wr_en  = we;
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    drive(a, d, 1'b1);
  endtask

  // Present an address with no write and check the read once it is valid.
  task automatic expect_read(input logic [7:0] a, input logic [7:0] e, input string name);
    drive(a, 8'h00, 1'b0);
`ifdef DATA_MEM_RDREG_EN
    @(posedge clk);
`endif
    #1;
    check(name, dat_out, e);
  endtask

  task automatic check_all_zero(input string name);
    int nz;
    logic [7:0] first_bad;
    nz = 0;
    first_bad = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (dut.mem_core[i] !== 8'h00) begin
        if (nz == 0) first_bad = dut.mem_core[i];
        nz++;
      end
    end
    check(name, first_bad, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    wr_en  = 1'b0;
    addr   = 8'h00;
    dat_in = 8'h00;
    #1 reset = 1'b0;
    #1;
    check("reset_dout", dat_out, 8'h00);
    check_all_zero("reset_array");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    // Write then read; neighbour untouched.
    write(OPA_HI, 8'hA5);
    expect_read(OPA_HI, 8'hA5, "wr_rd_9");
    expect_read(OPA_LO, 8'h00, "rd_8_zero");

    // Disabled write changes nothing.
    drive(RES_LO, 8'hFF, 1'b0);
    expect_read(RES_LO, 8'h00, "noweren_12");
    check("noweren_core12", dut.mem_core[12], 8'h00);

    // Address extremes do not alias.
    write(8'd255, 8'h3C);
    write(8'd0, 8'hC3);
    expect_read(8'd255, 8'h3C, "rd_255");
    expect_read(8'd0, 8'hC3, "rd_0");

    // Preload 13 entries, then reset between edges.
    for (int i = 1; i <= 13; i++) write(8'(i), 8'(i * 17));
    expect_read(8'd13, 8'hDD, "preload_13");
    expect_read(8'd2, 8'h22, "preload_2");
    @(posedge clk);
    #2;
    reset  = 1'b0;
    addr   = 8'd5;
    dat_in = 8'h55;
    wr_en  = 1'b1;
    #1;
    check_all_zero("midrst_clear");
    check("midrst_dout", dat_out, 8'h00);
    @(posedge clk);
    #1;
    check("rst_wr_blocked", dut.mem_core[5], 8'h00);
    #1 reset = 1'b1;
    // Write still pending on addr 5 lands on the next edge.
    expect_read(8'd5, 8'h55, "post_rst_wr");
    check("post_rst_other", dut.mem_core[255], 8'h00);

    // Hierarchical poke.
    drive(8'd0, 8'h00, 1'b0);
    dut.mem_core[OPB_HI] = 8'h3C;
    model[OPB_HI] = 8'h3C;
    addr = OPB_HI;
`ifdef DATA_MEM_RDREG_EN
    @(posedge clk);
`endif
    #1;
    check("poke_11", dat_out, 8'h3C);

    // Same-address read/write: new data after exactly one edge.
    drive(RES_HI, 8'h7E, 1'b1);
    @(posedge clk);
    #1;
    check("rdw_13", dat_out, 8'h7E);
    wr_en = 1'b0;
    expect_read(RES_HI, 8'h7E, "rdw_13_hold");

    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
